// File: rtl/ifq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : ifq_pkg
// Shared widths, queue entry type and PC helpers for the fetch queue.
// Rev     : 1.0
// ---------------------------------------------------------------------------
package ifq_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    // Wraps modulo 2^ADDR_W by construction of the fixed-width sum.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(PC_STEP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : ifq_fifo
// Synchronous FIFO with flush, any DEPTH >= 1; head reads as zero when empty.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : inst_fetch_queue
// Fetch PC owner, credit-limited imem requester and instruction queue to decode.
// Option : IFQ_BYPASS_EN routes a response straight to decode when the queue is empty.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W  = $clog2(DEPTH + MAX_OUTST + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [QCNT_W-1:0] q_count;
    logic              q_empty, q_full;
    logic              q_push, q_pop;
    ifq_entry_t        q_in, q_head;

    logic [OUT_W-1:0]  tag_count;
    logic              tag_empty, tag_full;
    logic [ADDR_W-1:0] tag_head;

    logic [OCC_W-1:0]  occupancy;
    logic              req_fire, rsp_fire, rsp_keep;

    // Queued words plus words still in flight must fit in the queue.
    assign occupancy      = OCC_W'(q_count) + OCC_W'(outst_q);
    assign imem_req_valid = reset && !redirect_valid
                            && (outst_q < OUT_W'(MAX_OUTST))
                            && (occupancy < OCC_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outst_q != '0);
    assign rsp_keep = rsp_fire && (drop_cnt_q == '0);

    assign q_in = '{pc: tag_head, inst: imem_rsp_data};

`ifdef IFQ_BYPASS_EN
    logic bypass;

    assign bypass     = q_empty && rsp_keep && !redirect_valid;
    assign inst_valid = !q_empty || bypass;
    assign inst_pc    = bypass ? tag_head      : q_head.pc;
    assign inst_data  = bypass ? imem_rsp_data : q_head.inst;
    assign q_push     = rsp_keep && !(bypass && inst_ready);
`else
    assign inst_valid = !q_empty;
    assign inst_pc    = q_head.pc;
    assign inst_data  = q_head.inst;
    assign q_push     = rsp_keep;
`endif

    assign q_pop = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            outst_d    = outst_q - OUT_W'(rsp_fire);
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = outst_q - OUT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            outst_d = outst_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);
            if (rsp_fire && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Tags of discarded responses are flushed on redirect, so only kept responses pop.
    ifq_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .head_data (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ifq_entry_t))
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    a_rsp_needs_credit: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outst_q != '0));
    a_tag_present: assert property (@(posedge clk) disable iff (!reset)
        rsp_keep |-> !tag_empty);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        req_fire |-> !tag_full);
    a_tag_within_outst: assert property (@(posedge clk) disable iff (!reset)
        tag_count <= outst_q);
    a_q_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (q_push && !redirect_valid) |-> (!q_full || q_pop));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_inst_fetch_queue
// Directed bench for inst_fetch_queue with a variable-latency in-order imem model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    inst_fetch_queue #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .MAX_OUTST (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, update the memory model
    // after it, and present the next response at the following negedge.
    task automatic tick();
        logic        fire, rfire;
        logic [31:0] a;
        #1;
        fire  = imem_req_valid && imem_req_ready;
        a     = imem_req_addr;
        rfire = imem_rsp_valid;
        if (inst_valid && inst_ready && !redirect_valid) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        @(posedge clk);
        cyc++;
        if (rfire && mq_addr.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fire) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
            acc_addr.push_back(a);
        end
        @(negedge clk);
        if (mq_addr.size() > 0 && cyc >= mq_due[0]) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        run(2);
        mq_addr.delete();
        mq_due.delete();
        acc_addr.delete();
        got_pc.delete();
        got_data.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        acc_addr.delete();
        got_pc.delete();
        got_data.delete();
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;
        @(negedge clk);

        // 1: reset state, then streaming with a 1-cycle memory
        lat = 1;
        apply_reset();
        #1;
        check("rst_req_valid",  {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid},     32'd0);
        check("rst_inst_data",  inst_data,               32'd0);
        check("rst_inst_pc",    inst_pc,                 32'd0);
        check("rst_req_addr",   imem_req_addr,           32'd0);
        @(negedge clk);
        reset = 1'b1;
        run(12);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_req_addr%0d", i), q_at(acc_addr, i), 32'(4 * i));
            check($sformatf("t1_inst_pc%0d", i),  q_at(got_pc, i),   32'(4 * i));
        end
        check("t1_inst_data0", q_at(got_data, 0), 32'hC0DE_0000);
        check("t1_inst_data3", q_at(got_data, 3), 32'hC0DE_000C);

        // 2: decode stalled, requests stop at DEPTH in flight plus queued
        inst_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        reset = 1'b1;
        run(10);
        #1;
        check("t2_req_count",  32'(acc_addr.size()),     32'd4);
        check("t2_req_valid",  {31'd0, imem_req_valid},  32'd0);
        check("t2_inst_valid", {31'd0, inst_valid},      32'd1);
        check("t2_head_pc",    inst_pc,                  32'h0);
        check("t2_head_data",  inst_data,                32'hC0DE_0000);
        inst_ready = 1'b1;
        run(10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_inst_pc%0d", i), q_at(got_pc, i), 32'(4 * i));
        end

        // 3: redirect with two requests in flight on a 3-cycle memory
        lat = 3;
        apply_reset();
        @(negedge clk);
        reset = 1'b1;
        run(2);
        check("t3_inflight", 32'(acc_addr.size()), 32'd2);
        do_redirect(32'h0000_0103);
        run(15);
        check("t3_req_addr0",  q_at(acc_addr, 0), 32'h100);
        check("t3_inst_pc0",   q_at(got_pc, 0),   32'h100);
        check("t3_inst_data0", q_at(got_data, 0), 32'hC0DE_0100);
        check("t3_inst_pc1",   q_at(got_pc, 1),   32'h104);

        // 4: redirect coinciding with a response and a pop
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (imem_rsp_valid && inst_valid) found = 1'b1;
            else tick();
        end
        check("t4_rsp_and_pop_seen", {31'd0, found}, 32'd1);
        do_redirect(32'h0000_0100);
        #1;
        check("t4_inst_valid_after", {31'd0, inst_valid}, 32'd0);
        run(12);
        check("t4_inst_pc0",   q_at(got_pc, 0),   32'h100);
        check("t4_inst_data0", q_at(got_data, 0), 32'hC0DE_0100);
        check("t4_inst_pc1",   q_at(got_pc, 1),   32'h104);

        // 5: PC wrap, and no request in the redirect cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        check("t5_no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        acc_addr.delete();
        got_pc.delete();
        got_data.delete();
        tick();
        redirect_valid = 1'b0;
        run(12);
        check("t5_req_addr0", q_at(acc_addr, 0), 32'hFFFF_FFF8);
        check("t5_req_addr1", q_at(acc_addr, 1), 32'hFFFF_FFFC);
        check("t5_req_addr2", q_at(acc_addr, 2), 32'h0000_0000);
        check("t5_inst_pc1",  q_at(got_pc, 1),   32'hFFFF_FFFC);
        check("t5_inst_pc2",  q_at(got_pc, 2),   32'h0000_0000);

        // 6: response-to-decode latency with an empty queue
        lat = 3;
        do_redirect(32'h0000_0300);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (imem_rsp_valid && mq_addr.size() > 0 && mq_addr[0] == 32'h300) found = 1'b1;
            else tick();
        end
        check("t6_rsp_seen", {31'd0, found}, 32'd1);
`ifdef IFQ_BYPASS_EN
        check("t6_valid_same_cycle", {31'd0, inst_valid}, 32'd1);
        check("t6_pc_same_cycle",    inst_pc,             32'h300);
        check("t6_data_same_cycle",  inst_data,           32'hC0DE_0300);
        tick();
        check("t6_popped_pc", q_at(got_pc, 0), 32'h300);
`else
        check("t6_valid_same_cycle", {31'd0, inst_valid}, 32'd0);
        tick();
        #1;
        check("t6_valid_next_cycle", {31'd0, inst_valid}, 32'd1);
        check("t6_pc_next_cycle",    inst_pc,             32'h300);
        check("t6_data_next_cycle",  inst_data,           32'hC0DE_0300);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
